// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline constants: instruction width, NOP bubble encoding, fetch FSM states.
package fetch_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned PC_W    = 16;

    // Encoding placed in IF/ID whenever the latch is flushed to a bubble.
    localparam logic [INSTR_W-1:0] NOP_ENC = 16'h0800;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        HALT_ST = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_ifid_reg.sv
// IF/ID pipeline latch with write enable and bubble flush.
module ifid_reg
    import fetch_ctrl_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               write_en,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc2,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc2,
    output logic               ifid_valid
);

    // Reset beats flush beats load; flush leaves pc2 untouched since a bubble never uses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc2   <= '0;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (write_en) begin
            ifid_instr <= instr;
            ifid_pc2   <= pc2;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: PC register, redirect/stall handling and HALT drain sequencing.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR    = NOP_ENC,
    parameter int unsigned        DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pcWrite,
    input  logic               ifid_write,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               halt_dec,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc2,
    output logic               ifid_valid,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES) + 1;

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_plus2;
    logic             ifid_we;
    logic             ifid_flush;

    assign pc_plus2  = pc_q + PC_W'(2);
    assign imem_addr = pc_q;

    // State, drain counter, PC and halted flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= '0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            halted  <= (state_d == HALT_ST);
        end
    end

    // Next-state and control: redirect > halt > per-signal hold > sequential fetch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ifid_flush = 1'b1;
                end else if (halt_dec) begin
                    ifid_flush = 1'b1;
                    state_d    = DRAIN;
                    cnt_d      = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    if (pcWrite) begin
                        pc_d = pc_plus2;
                    end
                    ifid_we = ifid_write;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = HALT_ST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALT_ST: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (ifid_we),
        .flush      (ifid_flush),
        .instr      (imem_instr),
        .pc2        (pc_plus2),
        .ifid_instr (ifid_instr),
        .ifid_pc2   (ifid_pc2),
        .ifid_valid (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected post-edge state, monitor compares.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcWrite = 1'b1;
    logic        ifid_write = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        halt_dec = 1'b0;
    logic [15:0] imem_instr;
    logic [15:0] imem_addr;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc2;
    logic        ifid_valid;
    logic        halted;

    typedef struct {
        int unsigned cyc;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        halt;
        logic        chk_pc2;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Instruction memory: data = 16'hA000 + address, combinational.
    assign imem_instr = 16'hA000 + imem_addr;

    fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcWrite       (pcWrite),
        .ifid_write    (ifid_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_dec      (halt_dec),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .ifid_instr    (ifid_instr),
        .ifid_pc2      (ifid_pc2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every queued expectation that belongs to the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk({e.tag, ".imem_addr"},  imem_addr,           e.addr);
            chk({e.tag, ".ifid_instr"}, ifid_instr,          e.instr);
            chk({e.tag, ".ifid_valid"}, {15'd0, ifid_valid}, {15'd0, e.valid});
            chk({e.tag, ".halted"},     {15'd0, halted},     {15'd0, e.halt});
            if (e.chk_pc2) chk({e.tag, ".ifid_pc2"}, ifid_pc2, e.pc2);
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next rising edge.
    task automatic step(input string tag, input logic rst, input logic pcw, input logic ifw,
                        input logic br, input logic [15:0] tgt, input logic hd,
                        input logic [15:0] ea, input logic [15:0] ei, input logic [15:0] ep,
                        input logic ev, input logic eh, input logic cp);
        exp_t e;
        rst_n         = rst;
        pcWrite       = pcw;
        ifid_write    = ifw;
        branch_taken  = br;
        branch_target = tgt;
        halt_dec      = hd;
        e.cyc = cyc + 1; e.addr = ea; e.instr = ei; e.pc2 = ep;
        e.valid = ev; e.halt = eh; e.chk_pc2 = cp; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        //    tag        rst pcw ifw br  tgt       hd  addr      instr     pc2       v  h  cp
        step("reset0",   0,  1,  1,  0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0, 1);
        step("reset1",   0,  1,  1,  1, 16'h1234, 1, 16'h0000, 16'h0800, 16'h0000, 0, 0, 1);
        step("norm0",    1,  1,  1,  0, 16'h0000, 0, 16'h0002, 16'hA000, 16'h0002, 1, 0, 1);
        step("norm1",    1,  1,  1,  0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 1);
        step("norm2",    1,  1,  1,  0, 16'h0000, 0, 16'h0006, 16'hA004, 16'h0006, 1, 0, 1);
        step("norm3",    1,  1,  1,  0, 16'h0000, 0, 16'h0008, 16'hA006, 16'h0008, 1, 0, 1);
        step("stall0",   1,  0,  0,  0, 16'h0000, 0, 16'h0008, 16'hA006, 16'h0008, 1, 0, 1);
        step("stall1",   1,  0,  0,  0, 16'h0000, 0, 16'h0008, 16'hA006, 16'h0008, 1, 0, 1);
        step("resume",   1,  1,  1,  0, 16'h0000, 0, 16'h000A, 16'hA008, 16'h000A, 1, 0, 1);
        step("pchold",   1,  0,  1,  0, 16'h0000, 0, 16'h000A, 16'hA00A, 16'h000C, 1, 0, 1);
        step("ifhold",   1,  1,  0,  0, 16'h0000, 0, 16'h000C, 16'hA00A, 16'h000C, 1, 0, 1);
        step("branch",   1,  0,  0,  1, 16'h0040, 1, 16'h0040, 16'h0800, 16'h0000, 0, 0, 0);
        step("post_br",  1,  1,  1,  0, 16'h0000, 0, 16'h0042, 16'hA040, 16'h0042, 1, 0, 1);
        step("br_fffe",  1,  1,  1,  1, 16'hFFFE, 0, 16'hFFFE, 16'h0800, 16'h0000, 0, 0, 0);
        step("wrap",     1,  1,  1,  0, 16'h0000, 0, 16'h0000, 16'h9FFE, 16'h0000, 1, 0, 1);
        step("br_000e",  1,  1,  1,  1, 16'h000E, 0, 16'h000E, 16'h0800, 16'h0000, 0, 0, 0);
        step("to_0010",  1,  1,  1,  0, 16'h0000, 0, 16'h0010, 16'hA00E, 16'h0010, 1, 0, 1);
        step("halt_e0",  1,  1,  1,  0, 16'h0000, 1, 16'h0010, 16'h0800, 16'h0000, 0, 0, 0);
        step("drain_e1", 1,  1,  1,  1, 16'h0077, 0, 16'h0010, 16'h0800, 16'h0000, 0, 0, 0);
        step("drain_e2", 1,  1,  1,  1, 16'h0077, 1, 16'h0010, 16'h0800, 16'h0000, 0, 0, 0);
        step("halt_e3",  1,  1,  1,  0, 16'h0000, 0, 16'h0010, 16'h0800, 16'h0000, 0, 1, 0);
        step("halt_ign", 1,  1,  1,  1, 16'h0077, 1, 16'h0010, 16'h0800, 16'h0000, 0, 1, 0);
        step("halt_hld", 1,  0,  0,  0, 16'h0000, 0, 16'h0010, 16'h0800, 16'h0000, 0, 1, 0);
        step("rst_halt", 0,  1,  1,  1, 16'h0077, 1, 16'h0000, 16'h0800, 16'h0000, 0, 0, 1);
        step("run_a0",   1,  1,  1,  0, 16'h0000, 0, 16'h0002, 16'hA000, 16'h0002, 1, 0, 1);
        step("run_a1",   1,  1,  1,  0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 1);
        step("halt2_e0", 1,  1,  1,  0, 16'h0000, 1, 16'h0004, 16'h0800, 16'h0000, 0, 0, 0);
        step("halt2_e1", 1,  1,  1,  0, 16'h0000, 0, 16'h0004, 16'h0800, 16'h0000, 0, 0, 0);
        step("rst_drain",0,  1,  1,  0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0, 1);
        step("run_b0",   1,  1,  1,  0, 16'h0000, 0, 16'h0002, 16'hA000, 16'h0002, 1, 0, 1);
        step("run_b1",   1,  1,  1,  0, 16'h0000, 0, 16'h0004, 16'hA002, 16'h0004, 1, 0, 1);
        step("run_b2",   1,  1,  1,  0, 16'h0000, 0, 16'h0006, 16'hA004, 16'h0006, 1, 0, 1);
        step("run_b3",   1,  1,  1,  0, 16'h0000, 0, 16'h0008, 16'hA006, 16'h0008, 1, 0, 1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: NOP_INSTR, default 16'h0800, encoding loaded into IF/ID on a flush (bubble).
REQ-002 Parameter: DRAIN_CYCLES, default 3, cycles after HALT decode before halted asserts (EX, MEM, WB).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 pcWrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
REQ-006 ifid_write  input  1  1 = IF/ID latch may load; 0 = hold IF/ID contents.
REQ-007 branch_taken  input  1  redirect request resolved downstream; flushes IF/ID.
REQ-008 branch_target  input  16  redirect PC, valid when branch_taken=1.
REQ-009 halt_dec  input  1  ID stage decoded HALT while ifid_valid=1.
REQ-010 imem_instr  input  16  instruction memory read data for imem_addr, same cycle.
REQ-011 imem_addr  output  16  current PC to instruction memory.
REQ-012 ifid_instr  output  16  IF/ID latched instruction.
REQ-013 ifid_pc2  output  16  IF/ID latched PC+2 of that instruction.
REQ-014 ifid_valid  output  1  1 = ifid_instr is a real fetched instruction, 0 = bubble.
REQ-015 halted  output  1  1 = pipeline drained after HALT; held until reset.

Function
REQ-016 States SHALL be RUN, DRAIN, HALT_ST; reset state RUN.
REQ-017 imem_addr SHALL equal the PC register combinationally.
REQ-018 PC increment SHALL be PC+2, modulo 2^16 (16'hFFFE+2 wraps to 16'h0000).
REQ-019 RUN, per-cycle priority: branch_taken > halt_dec > hold (pcWrite/ifid_write) > normal.
REQ-020 RUN, branch_taken=1: PC<=branch_target; ifid_instr<=NOP_INSTR, ifid_valid<=0; overrides pcWrite=0 and ifid_write=0.
REQ-021 RUN, halt_dec=1, no branch: PC held; IF/ID flushed to bubble; state<=DRAIN; counter<=DRAIN_CYCLES-1.
REQ-022 RUN, pcWrite=0: PC held; ifid_write=0: IF/ID (instr, pc2, valid) held; each honored independently.
REQ-023 RUN, normal: PC<=PC+2; ifid_instr<=imem_instr, ifid_pc2<=PC+2, ifid_valid<=1.
REQ-024 DRAIN: PC frozen; IF/ID held as bubble; inputs branch_taken, halt_dec, pcWrite, ifid_write ignored.
REQ-025 DRAIN: counter decrements each cycle; at counter=0 state<=HALT_ST.
REQ-026 halted SHALL be 1 exactly when state=HALT_ST (registered; first high DRAIN_CYCLES cycles after the halt_dec edge).
REQ-027 HALT_ST: all state frozen, all inputs ignored, exit only via reset.
REQ-028 Counter width SHALL be $clog2(DRAIN_CYCLES)+1 bits; DRAIN_CYCLES=1 goes DRAIN->HALT_ST next edge.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set PC=16'h0000, ifid_instr=NOP_INSTR, ifid_pc2=16'h0000, ifid_valid=0, state=RUN, counter=0, halted=0.
REQ-030 Reset SHALL take priority over all inputs in every state, including mid-DRAIN and HALT_ST.
REQ-031 First cycle after reset release SHALL present imem_addr=16'h0000 and fetch normally.

Structure
REQ-032 NOP encoding and state encodings (RUN=2'd0, DRAIN=2'd1, HALT_ST=2'd2) SHALL live in the shared pipeline constants include, used by decode and hazard logic.
REQ-033 IF/ID latch (instr, pc2, valid with write-enable and flush) SHALL be a sub-module ifid_reg; PC register and FSM stay in fetch_ctrl.
REQ-034 Unused state encoding 2'd3 SHALL recover to RUN on the next edge.

Verification
REQ-035 Reset, 4 normal cycles, imem returns 16'hA000+addr -> imem_addr 0,2,4,6; ifid_pc2 2,4,6,8; ifid_valid=1 from cycle 2.
REQ-036 At PC=16'h0008 drive pcWrite=0, ifid_write=0 for 2 cycles -> imem_addr stays 16'h0008, IF/ID unchanged, then resumes at 16'h000A.
REQ-037 branch_taken=1, target 16'h0040, same cycle pcWrite=0 -> next imem_addr=16'h0040, ifid_instr=16'h0800, ifid_valid=0.
REQ-038 halt_dec=1 at PC=16'h0010 -> PC frozen at 16'h0010, halted=0 for 2 cycles, halted=1 on 3rd edge; later branch_taken ignored.
REQ-039 PC preset to 16'hFFFE via branch, one normal cycle -> imem_addr=16'h0000.
REQ-040 rst_n=0 during DRAIN (counter=1) -> next edge state RUN, halted=0, imem_addr=16'h0000, ifid_valid=0.
